// File: rtl/measure_display.sv
// Samples a 14-bit measurement, converts it to BCD with an iterative double-dabble
// engine and drives four active-low seven-segment digits with blanking and over-range.
//
// state | meaning
// IDLE  | waiting for refresh tick or update request
// LOAD  | capture num/enable, clear BCD, arm bit counter
// SHIFT | one add-3/shift step per cycle, 14 steps
// LATCH | hex outputs show the new value, done pulses
module measure_display #(
  parameter int REFRESH_DIV = 500000,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [13:0] num,
  input  logic        enable,
  input  logic        update,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  state_t      state, state_nxt;
  logic [23:0] refresh_cnt;
  logic        tick;
  logic [13:0] bin, num_cap;
  logic        en_cap;
  logic [15:0] bcd, bcd_adj, bcd_nxt;
  logic [13:0] bin_nxt;
  logic [29:0] shifted;
  logic [3:0]  bit_cnt;
  logic [3:0]  d0, d1, d2, d3;
  logic        blank1, blank2, blank3;
  logic [6:0]  hex0_nxt, hex1_nxt, hex2_nxt, hex3_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_OFF;
    endcase
  endfunction

  assign tick = (refresh_cnt == 24'(REFRESH_DIV - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) refresh_cnt <= '0;
    else         refresh_cnt <= tick ? '0 : refresh_cnt + 24'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (tick || update) state_nxt = LOAD;
      LOAD:  begin busy = 1'b1; state_nxt = SHIFT; end
      SHIFT: begin busy = 1'b1; if (bit_cnt == 4'd0) state_nxt = LATCH; end
      LATCH: begin busy = 1'b1; done = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // add-3 correction per nibble, then one shift of the combined {bcd, bin} register
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin} << 1;
    bcd_nxt = shifted[29:14];
    bin_nxt = shifted[13:0];
  end

  // hex values are formed from the result of the final shift so they land with done
  always_comb begin
    d0 = bcd_nxt[3:0];
    d1 = bcd_nxt[7:4];
    d2 = bcd_nxt[11:8];
    d3 = bcd_nxt[15:12];
    blank3 = BLANK_ZEROS && (d3 == 4'd0);
    blank2 = blank3 && (d2 == 4'd0);
    blank1 = blank2 && (d1 == 4'd0);
    hex0_nxt = SEG_OFF;
    hex1_nxt = SEG_OFF;
    hex2_nxt = SEG_OFF;
    hex3_nxt = SEG_OFF;
    if (en_cap) begin
      if (num_cap > 14'd9999) begin
        hex0_nxt = SEG_DASH;
        hex1_nxt = SEG_DASH;
        hex2_nxt = SEG_DASH;
        hex3_nxt = SEG_DASH;
      end else begin
        hex0_nxt = seg7(d0);
        hex1_nxt = blank1 ? SEG_OFF : seg7(d1);
        hex2_nxt = blank2 ? SEG_OFF : seg7(d2);
        hex3_nxt = blank3 ? SEG_OFF : seg7(d3);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bin     <= '0;
      num_cap <= '0;
      en_cap  <= 1'b0;
      bcd     <= '0;
      bit_cnt <= '0;
      hex0    <= SEG_OFF;
      hex1    <= SEG_OFF;
      hex2    <= SEG_OFF;
      hex3    <= SEG_OFF;
    end else begin
      case (state)
        LOAD: begin
          bin     <= num;
          num_cap <= num;
          en_cap  <= enable;
          bcd     <= '0;
          bit_cnt <= 4'd13;
        end
        SHIFT: begin
          bcd     <= bcd_nxt;
          bin     <= bin_nxt;
          bit_cnt <= bit_cnt - 4'd1;
          if (bit_cnt == 4'd0) begin
            hex0 <= hex0_nxt;
            hex1 <= hex1_nxt;
            hex2 <= hex2_nxt;
            hex3 <= hex3_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_measure_display.sv
// Directed plus random checks of measure_display against a decimal-arithmetic display model.
module tb_measure_display;

  logic        clock = 1'b0;
  logic        resetn;
  logic [13:0] num;
  logic        enable;
  logic        update;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic        busy, done;
  logic [6:0]  b_hex0, b_hex1, b_hex2, b_hex3;
  logic        b_busy, b_done;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // main instance never self-refreshes during the run
  measure_display #(.REFRESH_DIV(16777215), .BLANK_ZEROS(1'b1)) dut (
    .clock(clock), .resetn(resetn), .num(num), .enable(enable), .update(update),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .busy(busy), .done(done)
  );

  measure_display #(.REFRESH_DIV(20), .BLANK_ZEROS(1'b0)) dut_b (
    .clock(clock), .resetn(resetn), .num(num), .enable(enable), .update(update),
    .hex0(b_hex0), .hex1(b_hex1), .hex2(b_hex2), .hex3(b_hex3), .busy(b_busy), .done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // expected {hex3,hex2,hex1,hex0} from decimal arithmetic
  function automatic logic [27:0] model(input int n, input bit en, input bit blank);
    logic [6:0] seg [10];
    logic [27:0] r;
    int p;
    seg = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (!en) return {4{7'h7F}};
    if (n > 9999) return {4{7'b0111111}};
    p = 1;
    for (int i = 0; i < 4; i++) begin
      if (blank && i > 0 && n < p) r[7*i +: 7] = 7'h7F;
      else                         r[7*i +: 7] = seg[(n / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  // pulse update and follow the conversion; optional mid-conversion disturbances
  task automatic convert(input string tag, input int n, input bit en,
                         input bit change_num, input bit poke);
    int ncyc;
    ncyc = poke ? 36 : 17;
    num = 14'(n);
    enable = en;
    update = 1'b1;
    @(negedge clock);
    update = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      check({tag, "_busy_done"}, {30'd0, busy, done},
            (k <= 15) ? 32'd2 : (k == 16) ? 32'd3 : 32'd0);
      if (k == 5 && change_num) num = 14'd42;
      if (k == 5 && poke) update = 1'b1;
      if (k == 6) update = 1'b0;
      @(negedge clock);
    end
    check({tag, "_hex"}, {4'd0, hex3, hex2, hex1, hex0}, {4'd0, model(n, en, 1'b1)});
  endtask

  initial begin
    int n;
    bit en;
    bit found;
    resetn = 1'b0;
    num = '0;
    enable = 1'b0;
    update = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_hex", {4'd0, hex3, hex2, hex1, hex0}, {4'd0, {4{7'h7F}}});
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    check("reset_b_hex", {4'd0, b_hex3, b_hex2, b_hex1, b_hex0}, {4'd0, {4{7'h7F}}});
    resetn = 1'b1;
    @(negedge clock);

    convert("n1234", 1234, 1'b1, 1'b0, 1'b0);
    convert("n7", 7, 1'b1, 1'b0, 1'b0);
    convert("n0", 0, 1'b1, 1'b0, 1'b0);
    convert("n9999", 9999, 1'b1, 1'b0, 1'b0);
    convert("n10000", 10000, 1'b1, 1'b0, 1'b0);
    convert("n16383", 16383, 1'b1, 1'b0, 1'b0);
    convert("n500_dis", 500, 1'b0, 1'b0, 1'b0);
    convert("n16383_dis", 16383, 1'b0, 1'b0, 1'b0);
    convert("n500_chg", 500, 1'b1, 1'b1, 1'b0);
    convert("n81_poke", 81, 1'b1, 1'b0, 1'b1);

    // reset during shift cycle 7 of a conversion of 4321
    convert("n56", 56, 1'b1, 1'b0, 1'b0);
    num = 14'd4321;
    enable = 1'b1;
    update = 1'b1;
    @(negedge clock);
    update = 1'b0;
    repeat (7) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("midrst_hex", {4'd0, hex3, hex2, hex1, hex0}, {4'd0, {4{7'h7F}}});
    check("midrst_busy_done", {30'd0, busy, done}, 32'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      check("midrst_no_done", {31'd0, done}, 32'd0);
    end
    check("midrst_hold", {4'd0, hex3, hex2, hex1, hex0}, {4'd0, {4{7'h7F}}});
    convert("n4321", 4321, 1'b1, 1'b0, 1'b0);

    // periodic refresh on the second instance (no leading-zero blanking)
    num = 14'd7;
    enable = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      found = b_done;
    end
    check("b_first_done", {31'd0, found}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      check("b_period", {31'd0, b_done}, (k == 20) ? 32'd1 : 32'd0);
    end
    check("b_hex_n7", {4'd0, b_hex3, b_hex2, b_hex1, b_hex0}, {4'd0, model(7, 1'b1, 1'b0)});
    // update coincident with the next refresh tick (4 cycles after done)
    num = 14'd305;
    repeat (4) @(negedge clock);
    update = 1'b1;
    @(negedge clock);
    update = 1'b0;
    for (int k = 5; k <= 24; k++) begin
      check("b_coincide", {31'd0, b_done}, (k == 20) ? 32'd1 : 32'd0);
      @(negedge clock);
    end
    check("b_hex_n305", {4'd0, b_hex3, b_hex2, b_hex1, b_hex0}, {4'd0, model(305, 1'b1, 1'b0)});
    check("a_hex_n305", {4'd0, hex3, hex2, hex1, hex0}, {4'd0, model(305, 1'b1, 1'b1)});

    for (int i = 0; i < 24; i++) begin
      n = (i % 3 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
      en = ($urandom_range(0, 7) != 0);
      convert("rand", n, en, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
